// File: rtl/gate_input_debouncer.sv
// Two-channel synchroniser and counter-based debouncer feeding a 2-input gate.
// Produces clean registered levels, 1-cycle edge pulses and a settled flag.
module gate_input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall,
    output logic settled
);

    localparam int CNT_W =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       w_raw;
    logic [1:0]       r_s1;
    logic [1:0]       r_s2;
    logic [1:0]       r_out;
    logic [1:0]       r_rise;
    logic [1:0]       r_fall;
    logic             r_settled;
    logic [CNT_W-1:0] r_cnt [2];

    logic [1:0]       w_diff;
    logic [1:0]       w_flip;
    logic [1:0]       w_quiet;

    assign w_raw = {b_raw, a_raw};

    always_comb begin
        w_diff  = '0;
        w_flip  = '0;
        w_quiet = '0;
        for (int i = 0; i < 2; i++) begin
            w_diff[i]  = r_s2[i] != r_out[i];
            w_flip[i]  = w_diff[i] && (r_cnt[i] == CNT_MAX);
            w_quiet[i] = !w_diff[i] && (r_cnt[i] == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_out     <= '0;
            r_rise    <= '0;
            r_fall    <= '0;
            r_settled <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1      <= w_raw;
            r_s2      <= r_s1;
            // Pulses follow the flip decision so they land one cycle after it.
            r_rise    <= w_flip & r_s2;
            r_fall    <= w_flip & ~r_s2;
            r_settled <= &w_quiet;
            for (int i = 0; i < 2; i++) begin
                if (!w_diff[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_flip[i]) begin
                    r_out[i] <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign a       = r_out[0];
    assign b       = r_out[1];
    assign a_rise  = r_rise[0];
    assign a_fall  = r_fall[0];
    assign b_rise  = r_rise[1];
    assign b_fall  = r_fall[1];
    assign settled = r_settled;

endmodule
